cv32e40p_obi_initiator: RTL and testbench

CV32E40P_OBI_INITIATOR -- requirements
Module: cv32e40p_obi_initiator

---
 rtl/cv32e40p_obi_initiator.sv | 181 ++++++++++++++++++
 tb/tb_cv32e40p_obi_initiator.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_obi_initiator.sv
// OBI data-bus initiator: one pending request, in-order response tagging.
// Optional address alignment/misalignment pulse: CV32E40P_OBI_INIT_ALIGN_CHECK_EN.
module cv32e40p_obi_initiator #(
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic                  cmd_we_i,
    input  logic [3:0]            cmd_be_i,
    input  logic [31:0]           cmd_wdata_i,

    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [31:0]           data_rdata_i,

    output logic                  rsp_valid_o,
    output logic                  rsp_we_o,
    output logic [31:0]           rsp_rdata_o,

    output logic                  idle_o,
    output logic                  misalign_o
);

    localparam int CNT_W = 3;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    state_t                   state_reg;
    state_t                   state_next;

    logic [CNT_W-1:0]         cnt_reg;
    logic [CNT_W-1:0]         cnt_plus_req;
    logic [PTR_W-1:0]         wr_ptr_reg;
    logic [PTR_W-1:0]         rd_ptr_reg;
    logic [MAX_OUTSTANDING-1:0] tag_reg;

    logic [ADDR_WIDTH-1:0]    addr_reg;
    logic [ADDR_WIDTH-1:0]    issue_addr;
    logic                     we_reg;
    logic [3:0]               be_reg;
    logic [31:0]              wdata_reg;

    logic                     rsp_valid_reg;
    logic                     rsp_we_reg;
    logic [31:0]              rsp_rdata_reg;

    logic                     accept;
    logic                     grant;
    logic                     pop;

    // A new command may only enter when the slot frees this cycle and the
    // pending request (if any) still leaves room among the outstanding ones.
    assign cnt_plus_req = cnt_reg + {{(CNT_W-1){1'b0}}, data_req_o};
    assign cmd_ready_o  = (!data_req_o || data_gnt_i) && (cnt_plus_req < MAX_CNT);
    assign accept       = cmd_valid_i && cmd_ready_o;
    assign grant        = data_req_o && data_gnt_i;
    assign pop          = data_rvalid_i && (cnt_reg != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_REQ;
            ST_REQ:  if (data_gnt_i && !accept) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        data_req_o = (state_reg == ST_REQ);
    end

`ifdef CV32E40P_OBI_INIT_ALIGN_CHECK_EN
    logic misalign_reg;

    assign issue_addr = {cmd_addr_i[ADDR_WIDTH-1:2], 2'b00};

    // Pulse lines up with the first cycle the aligned request is on the bus.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= accept && (cmd_addr_i[1:0] != 2'b00);
        end
    end

    assign misalign_o = misalign_reg;
`else
    assign issue_addr = cmd_addr_i;
    assign misalign_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_reg  <= '0;
            we_reg    <= 1'b0;
            be_reg    <= 4'h0;
            wdata_reg <= 32'h0;
        end else if (accept) begin
            addr_reg  <= issue_addr;
            we_reg    <= cmd_we_i;
            be_reg    <= cmd_be_i;
            wdata_reg <= cmd_wdata_i;
        end
    end

    assign data_addr_o  = addr_reg;
    assign data_we_o    = we_reg;
    assign data_be_o    = be_reg;
    assign data_wdata_o = wdata_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else begin
            case ({grant, pop})
                2'b10:   cnt_reg <= cnt_reg + 1'b1;
                2'b01:   cnt_reg <= cnt_reg - 1'b1;
                default: cnt_reg <= cnt_reg;
            endcase
        end
    end

    // Tag FIFO remembers the direction of each granted transfer so the
    // response can report it in grant order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            tag_reg    <= '0;
        end else begin
            if (grant) begin
                tag_reg[wr_ptr_reg] <= data_we_o;
                wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_reg <= 1'b0;
            rsp_we_reg    <= 1'b0;
            rsp_rdata_reg <= 32'h0;
        end else begin
            rsp_valid_reg <= pop;
            if (pop) begin
                rsp_we_reg    <= tag_reg[rd_ptr_reg];
                rsp_rdata_reg <= data_rdata_i;
            end
        end
    end

    assign rsp_valid_o = rsp_valid_reg;
    assign rsp_we_o    = rsp_we_reg;
    assign rsp_rdata_o = rsp_rdata_reg;
    assign idle_o      = !data_req_o && (cnt_reg == '0);

endmodule

// File: tb/tb_cv32e40p_obi_initiator.sv
// Directed self-checking bench for cv32e40p_obi_initiator (MAX_OUTSTANDING=2).
module tb_cv32e40p_obi_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_we;
    logic [3:0]  cmd_be;
    logic [31:0] cmd_wdata;
    logic        data_req;
    logic        data_gnt;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        rsp_valid;
    logic        rsp_we;
    logic [31:0] rsp_rdata;
    logic        idle;
    logic        misalign;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    cv32e40p_obi_initiator #(
        .ADDR_WIDTH      (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_addr_i    (cmd_addr),
        .cmd_we_i      (cmd_we),
        .cmd_be_i      (cmd_be),
        .cmd_wdata_i   (cmd_wdata),
        .data_req_o    (data_req),
        .data_gnt_i    (data_gnt),
        .data_addr_o   (data_addr),
        .data_we_o     (data_we),
        .data_be_o     (data_be),
        .data_wdata_o  (data_wdata),
        .data_rvalid_i (data_rvalid),
        .data_rdata_i  (data_rdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_we_o      (rsp_we),
        .rsp_rdata_o   (rsp_rdata),
        .idle_o        (idle),
        .misalign_o    (misalign)
    );

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_we = 1'b0; cmd_be = 4'h0;
        cmd_wdata = '0; data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
        tick(); tick();
        n_checks++; if (data_req !== 1'b0) begin n_fails++; $display("FAIL reset_req: got %b expected 0", data_req); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fails++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (rsp_rdata !== 32'h0) begin n_fails++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
        n_checks++; if (data_addr !== 32'h0 || data_wdata !== 32'h0) begin n_fails++; $display("FAIL reset_fields: got addr %h wdata %h expected 0/0", data_addr, data_wdata); end
        n_checks++; if (misalign !== 1'b0) begin n_fails++; $display("FAIL reset_misalign: got %b expected 0", misalign); end
        rst = 1'b0;
        #1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fails++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
        n_checks++; if (idle !== 1'b1) begin n_fails++; $display("FAIL reset_idle: got %b expected 1", idle); end
        $display("reset: done");
    endtask

    task automatic test_single_read();
        cmd_valid = 1'b1; cmd_addr = 32'h100; cmd_we = 1'b0; cmd_be = 4'hF; cmd_wdata = 32'h0;
        #1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fails++; $display("FAIL rd_ready: got %b expected 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0; data_gnt = 1'b1;
        #1;
        n_checks++; if (data_req !== 1'b1 || data_addr !== 32'h100 || data_we !== 1'b0) begin n_fails++; $display("FAIL rd_issue: got req %b addr %h we %b expected 1/100/0", data_req, data_addr, data_we); end
        n_checks++; if (idle !== 1'b0) begin n_fails++; $display("FAIL rd_busy: got %b expected 0", idle); end
        tick();
        data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = 32'hDEADBEEF;
        #1;
        n_checks++; if (data_req !== 1'b0 || idle !== 1'b0) begin n_fails++; $display("FAIL rd_drop: got req %b idle %b expected 0/0", data_req, idle); end
        tick();
        data_rvalid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_we !== 1'b0) begin n_fails++; $display("FAIL rd_rsp: got v %b data %h we %b expected 1/deadbeef/0", rsp_valid, rsp_rdata, rsp_we); end
        n_checks++; if (idle !== 1'b1) begin n_fails++; $display("FAIL rd_idle: got %b expected 1", idle); end
        tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fails++; $display("FAIL rd_pulse: got %b expected 0", rsp_valid); end
        $display("single_read: addr 0x100 rdata 0xdeadbeef");
    endtask

    task automatic test_grant_stall();
        cmd_valid = 1'b1; cmd_addr = 32'h200; cmd_we = 1'b1; cmd_be = 4'h3; cmd_wdata = 32'h11223344;
        tick();
        cmd_addr = 32'h204; cmd_we = 1'b0; cmd_be = 4'hC; cmd_wdata = 32'h55667788;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (data_req !== 1'b1 || data_addr !== 32'h200) begin n_fails++; $display("FAIL stall_addr[%0d]: got req %b addr %h expected 1/200", i, data_req, data_addr); end
            n_checks++; if (data_be !== 4'h3 || data_wdata !== 32'h11223344 || data_we !== 1'b1) begin n_fails++; $display("FAIL stall_fields[%0d]: got be %h wdata %h we %b expected 3/11223344/1", i, data_be, data_wdata, data_we); end
            n_checks++; if (cmd_ready !== 1'b0) begin n_fails++; $display("FAIL stall_ready[%0d]: got %b expected 0", i, cmd_ready); end
            tick();
        end
        data_gnt = 1'b1;
        #1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fails++; $display("FAIL stall_gnt_ready: got %b expected 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        n_checks++; if (data_req !== 1'b1 || data_addr !== 32'h204 || data_wdata !== 32'h55667788) begin n_fails++; $display("FAIL stall_next: got req %b addr %h wdata %h expected 1/204/55667788", data_req, data_addr, data_wdata); end
        tick();
        data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = 32'hA1;
        tick();
        data_rdata = 32'hA2;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_we !== 1'b1 || rsp_rdata !== 32'hA1) begin n_fails++; $display("FAIL stall_rsp0: got v %b we %b data %h expected 1/1/a1", rsp_valid, rsp_we, rsp_rdata); end
        tick();
        data_rvalid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_we !== 1'b0 || rsp_rdata !== 32'hA2) begin n_fails++; $display("FAIL stall_rsp1: got v %b we %b data %h expected 1/0/a2", rsp_valid, rsp_we, rsp_rdata); end
        tick();
        n_checks++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin n_fails++; $display("FAIL stall_end: got v %b idle %b expected 0/1", rsp_valid, idle); end
        $display("grant_stall: 5 stall cycles, write then read drained");
    endtask

    task automatic test_outstanding_limit();
        data_gnt = 1'b1; cmd_we = 1'b0; cmd_be = 4'hF;
        cmd_valid = 1'b1; cmd_addr = 32'h300;
        tick();
        cmd_addr = 32'h304;
        #1;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fails++; $display("FAIL lim_ready1: got %b expected 1", cmd_ready); end
        tick();
        cmd_addr = 32'h308;
        #1;
        n_checks++; if (cmd_ready !== 1'b0) begin n_fails++; $display("FAIL lim_ready2: got %b expected 0", cmd_ready); end
        tick();
        n_checks++; if (cmd_ready !== 1'b0 || data_req !== 1'b0) begin n_fails++; $display("FAIL lim_full: got ready %b req %b expected 0/0", cmd_ready, data_req); end
        tick();
        data_rvalid = 1'b1; data_rdata = 32'hB0;
        #1;
        n_checks++; if (cmd_ready !== 1'b0) begin n_fails++; $display("FAIL lim_hold: got %b expected 0", cmd_ready); end
        tick();
        data_rvalid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hB0) begin n_fails++; $display("FAIL lim_rsp0: got v %b data %h expected 1/b0", rsp_valid, rsp_rdata); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fails++; $display("FAIL lim_reopen: got %b expected 1", cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        n_checks++; if (data_req !== 1'b1 || data_addr !== 32'h308) begin n_fails++; $display("FAIL lim_third: got req %b addr %h expected 1/308", data_req, data_addr); end
        tick();
        data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = 32'hB1;
        tick();
        data_rdata = 32'hB2;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hB1) begin n_fails++; $display("FAIL lim_rsp1: got v %b data %h expected 1/b1", rsp_valid, rsp_rdata); end
        tick();
        data_rvalid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hB2) begin n_fails++; $display("FAIL lim_rsp2: got v %b data %h expected 1/b2", rsp_valid, rsp_rdata); end
        tick();
        n_checks++; if (idle !== 1'b1) begin n_fails++; $display("FAIL lim_idle: got %b expected 1", idle); end
        $display("outstanding_limit: 3 reads, third issued after first response");
    endtask

    task automatic test_ordering();
        cmd_valid = 1'b1; cmd_addr = 32'h400; cmd_we = 1'b1; cmd_wdata = 32'hCAFE;
        tick();
        data_gnt = 1'b1; cmd_addr = 32'h404; cmd_we = 1'b0;
        tick();
        cmd_valid = 1'b0; data_rvalid = 1'b1; data_rdata = 32'hC0FFEE00;
        #1;
        n_checks++; if (data_req !== 1'b1 || data_we !== 1'b0) begin n_fails++; $display("FAIL ord_read_req: got req %b we %b expected 1/0", data_req, data_we); end
        tick();
        data_gnt = 1'b0; data_rdata = 32'h12345678;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_we !== 1'b1 || rsp_rdata !== 32'hC0FFEE00) begin n_fails++; $display("FAIL ord_rsp_w: got v %b we %b data %h expected 1/1/c0ffee00", rsp_valid, rsp_we, rsp_rdata); end
        n_checks++; if (cmd_ready !== 1'b1 || idle !== 1'b0) begin n_fails++; $display("FAIL ord_cnt_kept: got ready %b idle %b expected 1/0", cmd_ready, idle); end
        tick();
        data_rvalid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_we !== 1'b0 || rsp_rdata !== 32'h12345678) begin n_fails++; $display("FAIL ord_rsp_r: got v %b we %b data %h expected 1/0/12345678", rsp_valid, rsp_we, rsp_rdata); end
        n_checks++; if (idle !== 1'b1) begin n_fails++; $display("FAIL ord_idle: got %b expected 1", idle); end
        tick();
        $display("ordering: write rsp_we=1 then read rsp_we=0");
    endtask

    task automatic test_spurious();
        data_rvalid = 1'b1; data_rdata = 32'hBAD;
        tick();
        data_rvalid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin n_fails++; $display("FAIL spur_idle: got v %b idle %b expected 0/1", rsp_valid, idle); end
        data_gnt = 1'b1; cmd_we = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 32'h500;
        tick();
        cmd_addr = 32'h504;
        tick();
        cmd_valid = 1'b0;
        tick();
        data_gnt = 1'b0;
        n_checks++; if (idle !== 1'b0 || cmd_ready !== 1'b0) begin n_fails++; $display("FAIL spur_two_out: got idle %b ready %b expected 0/0", idle, cmd_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (idle !== 1'b1 || data_req !== 1'b0 || data_addr !== 32'h0) begin n_fails++; $display("FAIL spur_reset: got idle %b req %b addr %h expected 1/0/0", idle, data_req, data_addr); end
        data_rvalid = 1'b1; data_rdata = 32'hBAD2;
        tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_fails++; $display("FAIL spur_rv1: got %b expected 0", rsp_valid); end
        tick();
        data_rvalid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || idle !== 1'b1 || cmd_ready !== 1'b1) begin n_fails++; $display("FAIL spur_rv2: got v %b idle %b ready %b expected 0/1/1", rsp_valid, idle, cmd_ready); end
        $display("spurious: rvalid ignored in idle and after reset");
    endtask

    task automatic test_misalign();
        logic [31:0] exp_addr;
        logic        exp_mis;
`ifdef CV32E40P_OBI_INIT_ALIGN_CHECK_EN
        exp_addr = 32'h100; exp_mis = 1'b1;
`else
        exp_addr = 32'h103; exp_mis = 1'b0;
`endif
        cmd_valid = 1'b1; cmd_addr = 32'h103; cmd_we = 1'b0;
        tick();
        cmd_valid = 1'b0; data_gnt = 1'b1;
        n_checks++; if (data_addr !== exp_addr) begin n_fails++; $display("FAIL mis_addr: got %h expected %h", data_addr, exp_addr); end
        n_checks++; if (misalign !== exp_mis) begin n_fails++; $display("FAIL mis_pulse: got %b expected %b", misalign, exp_mis); end
        tick();
        data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = 32'h77;
        n_checks++; if (misalign !== 1'b0) begin n_fails++; $display("FAIL mis_clear: got %b expected 0", misalign); end
        tick();
        data_rvalid = 1'b0;
        n_checks++; if (rsp_valid !== 1'b1 || idle !== 1'b1) begin n_fails++; $display("FAIL mis_rsp: got v %b idle %b expected 1/1", rsp_valid, idle); end
        tick();
        $display("misalign: addr 0x103 issued as %h", exp_addr);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_grant_stall();
        test_outstanding_limit();
        test_ordering();
        test_spurious();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
